// File: rtl/fairy_dsram_arbiter.sv
// fairy_dsram_arbiter
//   Lets two requesters share the single-port data SRAM. Port 0 is the memory
//   stage load/store path, port 1 is a secondary master such as a debug or DMA
//   loader. The arbiter grants at most one access per cycle and drives the SRAM
//   address, byte enables and write data from the granted port. It then returns
//   read data, which arrives one cycle after the read is issued, to the port
//   that made the load.
//   Port 0 has fixed priority. A starvation counter forces a port 1 grant once
//   port 1 has been denied MAX_WAIT cycles in a row.
// Parameters
//   MAX_WAIT  consecutive port 1 denials before port 1 is forced (1..15)
//   CNT_W     starvation counter width, 2**CNT_W-1 >= MAX_WAIT
// Ports
//   clk, reset_n              clock (rising edge), async active-low reset
//   pN_req_i / pN_wr_i        request (held until ack), 1 = store
//   pN_addr_i / pN_cen_i      byte address, store byte enables
//   pN_wdata_i                store data
//   pN_ack_o                  access accepted this cycle (combinational)
//   pN_rvalid_o / pN_rdata_o  load data return, one cycle after ack
//   data_sram_*               SRAM side; every output is zero when idle
module fairy_dsram_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p0_req_i,
  input  logic        p0_wr_i,
  input  logic [31:0] p0_addr_i,
  input  logic [3:0]  p0_cen_i,
  input  logic [31:0] p0_wdata_i,
  output logic        p0_ack_o,
  output logic        p0_rvalid_o,
  output logic [31:0] p0_rdata_o,
  input  logic        p1_req_i,
  input  logic        p1_wr_i,
  input  logic [31:0] p1_addr_i,
  input  logic [3:0]  p1_cen_i,
  input  logic [31:0] p1_wdata_i,
  output logic        p1_ack_o,
  output logic        p1_rvalid_o,
  output logic [31:0] p1_rdata_o,
  input  logic [31:0] data_sram_rdata_i,
  output logic [31:0] data_sram_addr_o,
  output logic [3:0]  data_sram_cen_o,
  output logic [31:0] data_sram_wdata_o,
  output logic        data_sram_wr_o
);

  logic [CNT_W-1:0] wait_cnt;
  logic             force1;
  logic             gnt0;
  logic             gnt1;
  logic             wr_granted;
  logic             rd_pend;
  logic             rd_owner;

  assign force1 = (wait_cnt == CNT_W'(MAX_WAIT));
  assign gnt1   = p1_req_i & (~p0_req_i | force1);
  assign gnt0   = p0_req_i & ~gnt1;

  assign p0_ack_o = gnt0;
  assign p1_ack_o = gnt1;

  // SRAM request mux. A load always enables all four byte lanes.
  always_comb begin
    data_sram_addr_o  = '0;
    data_sram_cen_o   = '0;
    data_sram_wdata_o = '0;
    data_sram_wr_o    = 1'b0;
    if (gnt1) begin
      data_sram_addr_o  = p1_addr_i;
      data_sram_cen_o   = p1_wr_i ? p1_cen_i : 4'b1111;
      data_sram_wdata_o = p1_wdata_i;
      data_sram_wr_o    = p1_wr_i;
    end else if (gnt0) begin
      data_sram_addr_o  = p0_addr_i;
      data_sram_cen_o   = p0_wr_i ? p0_cen_i : 4'b1111;
      data_sram_wdata_o = p0_wdata_i;
      data_sram_wr_o    = p0_wr_i;
    end
  end

  assign wr_granted = data_sram_wr_o;

  // Starvation counter. It counts consecutive denied port 1 cycles and holds at
  // MAX_WAIT so that the force condition stays asserted until port 1 is served.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (gnt1 || !p1_req_i) begin
      wait_cnt <= '0;
    end else if (!force1) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Read return tracking: records whether a load was issued and which port owns it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend  <= (gnt0 | gnt1) & ~wr_granted;
      rd_owner <= gnt1;
    end
  end

  assign p0_rvalid_o = rd_pend & ~rd_owner;
  assign p1_rvalid_o = rd_pend & rd_owner;
  assign p0_rdata_o  = p0_rvalid_o ? data_sram_rdata_i : '0;
  assign p1_rdata_o  = p1_rvalid_o ? data_sram_rdata_i : '0;

endmodule

// File: tb/tb_fairy_dsram_arbiter.sv
// tb_fairy_dsram_arbiter
//   Applies directed vectors with hand-computed expectations to
//   fairy_dsram_arbiter (MAX_WAIT = 4). A small SRAM model returns read data
//   one cycle after a read is issued. Address 0x100 reads as 0xDEADBEEF; any
//   other address reads as addr ^ 0xA5A50000.
module tb_fairy_dsram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        p0_req_i = 1'b0, p0_wr_i = 1'b0;
  logic [31:0] p0_addr_i = '0, p0_wdata_i = '0;
  logic [3:0]  p0_cen_i = '0;
  logic        p0_ack_o, p0_rvalid_o;
  logic [31:0] p0_rdata_o;
  logic        p1_req_i = 1'b0, p1_wr_i = 1'b0;
  logic [31:0] p1_addr_i = '0, p1_wdata_i = '0;
  logic [3:0]  p1_cen_i = '0;
  logic        p1_ack_o, p1_rvalid_o;
  logic [31:0] p1_rdata_o;
  logic [31:0] sram_rdata = '0;
  logic [31:0] data_sram_addr_o, data_sram_wdata_o;
  logic [3:0]  data_sram_cen_o;
  logic        data_sram_wr_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  fairy_dsram_arbiter #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req_i(p0_req_i), .p0_wr_i(p0_wr_i), .p0_addr_i(p0_addr_i),
    .p0_cen_i(p0_cen_i), .p0_wdata_i(p0_wdata_i), .p0_ack_o(p0_ack_o),
    .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req_i), .p1_wr_i(p1_wr_i), .p1_addr_i(p1_addr_i),
    .p1_cen_i(p1_cen_i), .p1_wdata_i(p1_wdata_i), .p1_ack_o(p1_ack_o),
    .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
    .data_sram_rdata_i(sram_rdata), .data_sram_addr_o(data_sram_addr_o),
    .data_sram_cen_o(data_sram_cen_o), .data_sram_wdata_o(data_sram_wdata_o),
    .data_sram_wr_o(data_sram_wr_o)
  );

  always_ff @(posedge clk) begin
    if (data_sram_cen_o != 4'h0 && !data_sram_wr_o)
      sram_rdata <= (data_sram_addr_o == 32'h100) ? 32'hDEADBEEF
                                                  : (data_sram_addr_o ^ 32'hA5A50000);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_cen"},   32'(data_sram_cen_o), 32'h0);
    check_eq({tag, "_wr"},    32'(data_sram_wr_o), 32'h0);
    check_eq({tag, "_addr"},  data_sram_addr_o, 32'h0);
    check_eq({tag, "_wdata"}, data_sram_wdata_o, 32'h0);
  endtask

  initial begin
    // Reset state
    #2;
    check_eq("rst_p0_rvalid", 32'(p0_rvalid_o), 32'h0);
    check_eq("rst_p1_rvalid", 32'(p1_rvalid_o), 32'h0);
    check_eq("rst_p0_rdata", p0_rdata_o, 32'h0);
    check_eq("rst_ack", {30'h0, p1_ack_o, p0_ack_o}, 32'h0);
    check_idle("rst");
    step();
    reset_n = 1'b1;

    // 1: p0 load 0x100 alone. The requester cen is ignored for loads.
    step();
    p0_req_i = 1'b1; p0_wr_i = 1'b0; p0_addr_i = 32'h100; p0_cen_i = 4'b0010;
    #1;
    check_eq("t1_ack0", 32'(p0_ack_o), 32'h1);
    check_eq("t1_ack1", 32'(p1_ack_o), 32'h0);
    check_eq("t1_cen", 32'(data_sram_cen_o), 32'hF);
    check_eq("t1_wr", 32'(data_sram_wr_o), 32'h0);
    check_eq("t1_addr", data_sram_addr_o, 32'h100);
    step();
    p0_req_i = 1'b0;
    #1;
    check_eq("t1_rvalid0", 32'(p0_rvalid_o), 32'h1);
    check_eq("t1_rdata0", p0_rdata_o, 32'hDEADBEEF);
    check_eq("t1_rvalid1", 32'(p1_rvalid_o), 32'h0);
    check_eq("t1_rdata1", p1_rdata_o, 32'h0);

    // 6: idle cycles
    for (int i = 0; i < 3; i++) begin
      check_idle("t6_idle");
      step();
      check_eq("t6_rvalid0", 32'(p0_rvalid_o), 32'h0);
    end

    // 3: p1 store with p0 idle. p0 has non-zero fields that must not leak.
    p0_addr_i = 32'h5555_0000; p0_wdata_i = 32'h1234_5678;
    p1_req_i = 1'b1; p1_wr_i = 1'b1; p1_addr_i = 32'h204; p1_cen_i = 4'b0011;
    p1_wdata_i = 32'h0000ABCD;
    #1;
    check_eq("t3_ack1", 32'(p1_ack_o), 32'h1);
    check_eq("t3_ack0", 32'(p0_ack_o), 32'h0);
    check_eq("t3_wr", 32'(data_sram_wr_o), 32'h1);
    check_eq("t3_cen", 32'(data_sram_cen_o), 32'h3);
    check_eq("t3_addr", data_sram_addr_o, 32'h204);
    check_eq("t3_wdata", data_sram_wdata_o, 32'h0000ABCD);
    step();
    p1_req_i = 1'b0; p1_wr_i = 1'b0;
    #1;
    check_eq("t3_rvalid1", 32'(p1_rvalid_o), 32'h0);
    check_eq("t3_rvalid0", 32'(p0_rvalid_o), 32'h0);

    // 4: p0 load at t, p1 load at t+1, then a p0 store at t+2
    step();
    p0_req_i = 1'b1; p0_wr_i = 1'b0; p0_addr_i = 32'h100;
    #1;
    check_eq("t4_ack0", 32'(p0_ack_o), 32'h1);
    step();
    p0_req_i = 1'b0;
    p1_req_i = 1'b1; p1_wr_i = 1'b0; p1_addr_i = 32'h300;
    #1;
    check_eq("t4_ack1", 32'(p1_ack_o), 32'h1);
    check_eq("t4_addr1", data_sram_addr_o, 32'h300);
    check_eq("t4_rvalid0", 32'(p0_rvalid_o), 32'h1);
    check_eq("t4_rdata0", p0_rdata_o, 32'hDEADBEEF);
    check_eq("t4_rvalid1_early", 32'(p1_rvalid_o), 32'h0);
    step();
    p1_req_i = 1'b0;
    p0_req_i = 1'b1; p0_wr_i = 1'b1; p0_addr_i = 32'h40; p0_cen_i = 4'b1100;
    p0_wdata_i = 32'hCAFE_0000;
    #1;
    check_eq("t4_rvalid1", 32'(p1_rvalid_o), 32'h1);
    check_eq("t4_rdata1", p1_rdata_o, 32'hA5A50300);
    check_eq("t4_rvalid0_none", 32'(p0_rvalid_o), 32'h0);
    check_eq("t4_rdata0_none", p0_rdata_o, 32'h0);
    check_eq("t4_st_cen", 32'(data_sram_cen_o), 32'hC);
    check_eq("t4_st_wr", 32'(data_sram_wr_o), 32'h1);
    step();
    p0_req_i = 1'b0; p0_wr_i = 1'b0;
    #1;
    check_eq("t4_st_rvalid0", 32'(p0_rvalid_o), 32'h0);

    // 2: both ports request loads every cycle. p1 is forced every 5th cycle.
    step();
    p0_req_i = 1'b1; p0_wr_i = 1'b0; p0_addr_i = 32'h10;
    p1_req_i = 1'b1; p1_wr_i = 1'b0; p1_addr_i = 32'h20;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("t2_ack1", 32'(p1_ack_o), (i % 5 == 4) ? 32'h1 : 32'h0);
      check_eq("t2_ack0", 32'(p0_ack_o), (i % 5 == 4) ? 32'h0 : 32'h1);
      check_eq("t2_cnt_bound", 32'(dut.wait_cnt <= 4), 32'h1);
      if (i > 0) begin
        check_eq("t2_rvalid1", 32'(p1_rvalid_o), ((i - 1) % 5 == 4) ? 32'h1 : 32'h0);
        check_eq("t2_rvalid0", 32'(p0_rvalid_o), ((i - 1) % 5 == 4) ? 32'h0 : 32'h1);
      end
      step();
    end
    p0_req_i = 1'b0; p1_req_i = 1'b0;

    // 5a: reset asserted after the grant, before the return edge
    step();
    p0_req_i = 1'b1; p0_addr_i = 32'h100;
    #1;
    check_eq("t5_ack0", 32'(p0_ack_o), 32'h1);
    reset_n = 1'b0;
    p0_req_i = 1'b0;
    step();
    check_eq("t5a_rvalid0", 32'(p0_rvalid_o), 32'h0);
    // 5b: reset asserted while the return is already showing
    #1;
    reset_n = 1'b1;
    step();
    p0_req_i = 1'b1;
    step();
    p0_req_i = 1'b0;
    #1;
    check_eq("t5b_rvalid0_pre", 32'(p0_rvalid_o), 32'h1);
    reset_n = 1'b0;
    #1;
    check_eq("t5b_rvalid0_rst", 32'(p0_rvalid_o), 32'h0);
    check_eq("t5b_rdata0_rst", p0_rdata_o, 32'h0);
    #2;
    reset_n = 1'b1;
    check_eq("t5_cnt", 32'(dut.wait_cnt), 32'h0);
    // Next request after reset is serviced normally
    step();
    p1_req_i = 1'b1; p1_addr_i = 32'h300;
    #1;
    check_eq("t5_ack1", 32'(p1_ack_o), 32'h1);
    step();
    p1_req_i = 1'b0;
    #1;
    check_eq("t5_rvalid1", 32'(p1_rvalid_o), 32'h1);
    check_eq("t5_rdata1", p1_rdata_o, 32'hA5A50300);
    check_idle("t5_idle");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
